// File: rtl/adc_pkg.sv
// Shared types and frame geometry for the serial ADC frame controller.
// No ports; imported by adc_frame_ctrl and sclk_tick_gen.
package adc_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CONV  = 2'd1,
      QUIET = 2'd2
   } state_e;

   localparam int FRAME_BITS = 16;
   localparam int DATA_BITS  = 12;
   localparam int AVG_FRAMES = 4;
   localparam int AVG_SHIFT  = 2;

endpackage

// File: rtl/adc_frame_ctrl_sclk_tick_gen.sv
// sclk generator for one ADC frame.
// While run is high, a half-period counter counts 0..SCLK_HALF-1; at terminal
// count sclk toggles and the counter wraps. While run is low, sclk idles high.
// Ports:
//   clk, rst     system clock, synchronous active-high reset
//   run          generate sclk edges
//   sclk         registered serial clock, idles high
//   rise, fall   one-clk strobes, high in the cycle whose edge moves sclk 0->1 / 1->0
module sclk_tick_gen
   import adc_pkg::*;
#(
   parameter int SCLK_HALF = 66
) (
   input  logic clk,
   input  logic rst,
   input  logic run,
   output logic sclk,
   output logic rise,
   output logic fall
);

   localparam int CW = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;

   logic [CW-1:0] cnt_q, cnt_d;
   logic          sclk_q, sclk_d;
   logic          tc;

   always_comb begin
      tc     = run && (cnt_q == CW'(SCLK_HALF - 1));
      cnt_d  = '0;
      sclk_d = 1'b1;
      if (run) begin
         sclk_d = sclk_q;
         if (tc) begin
            sclk_d = ~sclk_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q  <= '0;
         sclk_q <= 1'b1;
      end else begin
         cnt_q  <= cnt_d;
         sclk_q <= sclk_d;
      end
   end

   assign sclk = sclk_q;
   assign rise = tc && !sclk_q;
   assign fall = tc && sclk_q;

endmodule

// File: rtl/adc_frame_ctrl.sv
// Frame-aware sequencer for one serial ADC (16-bit frame, 12-bit result, MSB
// first) with a valid/ready result port and overrun flag.
// Optional build macro ADC_AVG_EN: deliver the truncated mean of every four
// results instead of each raw result.
// Ports:
//   clk, rst      system clock, synchronous active-high reset
//   en            run enable; frames repeat back to back while high
//   sdata         ADC serial data
//   cs_n, sclk    ADC chip select (active low) and serial clock (idles high)
//   sample        latest result; sample_valid / sample_ready handshake
//   overrun       one-clk pulse when an unconsumed result is overwritten
//
// state | meaning
// IDLE  | cs_n high, waiting for en
// CONV  | cs_n low, sclk running, shifting in FRAME_BITS bits
// QUIET | cs_n high for QUIET_CLKS clks between frames
module adc_frame_ctrl
   import adc_pkg::*;
#(
   parameter int SCLK_HALF  = 66,
   parameter int QUIET_CLKS = 133
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic                 sdata,
   output logic                 cs_n,
   output logic                 sclk,
   output logic [DATA_BITS-1:0] sample,
   output logic                 sample_valid,
   input  logic                 sample_ready,
   output logic                 overrun
);

   localparam int QW = $clog2(QUIET_CLKS + 1);
   localparam int BW = $clog2(FRAME_BITS);

   state_e               state_q, state_d;
   logic                 cs_n_q, cs_n_d;
   logic [QW-1:0]        quiet_q, quiet_d;
   logic [BW-1:0]        bit_q, bit_d;
   // Only the last DATA_BITS-1 captured bits are kept; the final bit comes
   // straight from sdata on the load cycle, so the leading bits fall off.
   logic [DATA_BITS-2:0] shift_q, shift_d;
   logic                 armed_q, armed_d;
   logic [DATA_BITS-1:0] sample_q, sample_d;
   logic                 valid_q, valid_d;
   logic                 ovr_q, ovr_d;
   logic                 run, sclk_rise, sclk_fall;
   logic                 load, deliver;
   logic [DATA_BITS-1:0] result, deliver_val;

   assign run = (state_q == CONV);

   sclk_tick_gen #(.SCLK_HALF(SCLK_HALF)) u_tick (
      .clk  (clk),
      .rst  (rst),
      .run  (run),
      .sclk (sclk),
      .rise (sclk_rise),
      .fall (sclk_fall)
   );

   always_comb begin
      state_d = state_q;
      quiet_d = quiet_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      armed_d = armed_q;
      load    = 1'b0;
      result  = {shift_q, sdata};
      case (state_q)
         IDLE: begin
            if (en) state_d = CONV;
         end
         CONV: begin
            // A capture is only accepted once this frame has produced a falling edge.
            if (sclk_fall) armed_d = 1'b1;
            if (sclk_rise && armed_q) begin
               shift_d = {shift_q[DATA_BITS-3:0], sdata};
               bit_d   = bit_q + 1'b1;
               if (bit_q == BW'(FRAME_BITS - 1)) begin
                  load    = 1'b1;
                  state_d = QUIET;
                  quiet_d = QW'(QUIET_CLKS - 1);
                  bit_d   = '0;
                  armed_d = 1'b0;
               end
            end
         end
         QUIET: begin
            if (quiet_q == '0) begin
               state_d = en ? CONV : IDLE;
            end else begin
               quiet_d = quiet_q - 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      cs_n_d = (state_d != CONV);
   end

`ifdef ADC_AVG_EN
   localparam int FW = $clog2(AVG_FRAMES);

   logic [DATA_BITS+1:0] acc_q, acc_d, acc_sum;
   logic [FW-1:0]        frm_q, frm_d;

   always_comb begin
      acc_sum     = acc_q + {2'b00, result};
      acc_d       = acc_q;
      frm_d       = frm_q;
      deliver     = 1'b0;
      deliver_val = DATA_BITS'(acc_sum >> AVG_SHIFT);
      if (load) begin
         if (frm_q == FW'(AVG_FRAMES - 1)) begin
            deliver = 1'b1;
            acc_d   = '0;
            frm_d   = '0;
         end else begin
            acc_d = acc_sum;
            frm_d = frm_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q <= '0;
         frm_q <= '0;
      end else begin
         acc_q <= acc_d;
         frm_q <= frm_d;
      end
   end
`else
   always_comb begin
      deliver     = load;
      deliver_val = result;
   end
`endif

   // A load on the same clk as a handshake replaces the consumed sample, so
   // valid stays high; overrun only when the old one was never taken.
   always_comb begin
      sample_d = deliver ? deliver_val : sample_q;
      valid_d  = deliver || (valid_q && !sample_ready);
      ovr_d    = deliver && valid_q && !sample_ready;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         cs_n_q   <= 1'b1;
         quiet_q  <= '0;
         bit_q    <= '0;
         shift_q  <= '0;
         armed_q  <= 1'b0;
         sample_q <= '0;
         valid_q  <= 1'b0;
         ovr_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cs_n_q   <= cs_n_d;
         quiet_q  <= quiet_d;
         bit_q    <= bit_d;
         shift_q  <= shift_d;
         armed_q  <= armed_d;
         sample_q <= sample_d;
         valid_q  <= valid_d;
         ovr_q    <= ovr_d;
      end
   end

   assign cs_n         = cs_n_q;
   assign sample       = sample_q;
   assign sample_valid = valid_q;
   assign overrun      = ovr_q;

endmodule

// File: doc/adc_frame_ctrl.md
Name: adc_frame_ctrl

Overview:
Sequences one serial ADC (16-bit frame, 12-bit result, MSB first) from the system clock. It drives cs_n and sclk and shifts in sdata. Each result is presented on a valid/ready interface to the equaliser datapath. It replaces free-running divider pulses with a frame-aware state machine that has defined chip-select, quiet-time and backpressure behaviour.

Parameters:
SCLK_HALF, 66, sclk half-period in clk cycles (100 MHz / 132 ≈ 758 kHz sclk); legal range ≥2
QUIET_CLKS, 133, clk cycles cs_n is held high between frames; legal range ≥1
FRAME_BITS, 16, sclk periods per conversion frame
DATA_BITS, 12, result width taken from the last DATA_BITS captured bits

Ports:
clk  in  1  system clock; all logic is on its rising edge
rst  in  1  synchronous, active-high reset
en  in  1  run enable; while 1, frames repeat back to back, separated by quiet time
sdata  in  1  ADC serial data output
cs_n  out  1  ADC chip select, active low
sclk  out  1  ADC serial clock, registered, idles high
sample  out  DATA_BITS  latest conversion result
sample_valid  out  1  sample holds an unconsumed result
sample_ready  in  1  consumer accepts sample when sample_valid && sample_ready
overrun  out  1  one-clk pulse: an unconsumed result was overwritten

Behaviour:
- Clocking and reset: one clock, clk. rst is synchronous and active-high. rst takes priority over everything, including mid-frame.
- Reset values: cs_n=1, sclk=1, sample=0, sample_valid=0, overrun=0, state=IDLE, all counters 0.
- FSM states: IDLE, CONV, QUIET.
- IDLE → CONV: on the clk where en=1. cs_n goes 0 on the next edge; sclk stays 1.
- CONV:
  - Half-period counter runs 0..SCLK_HALF-1. At terminal count it toggles sclk and wraps.
  - Each sclk 1→0 toggle is a fall strobe. Each 0→1 toggle is a rise strobe.
  - On a rise strobe the controller registers sdata into the shift register (MSB first) and increments the bit counter.
  - First fall occurs SCLK_HALF clks after cs_n falls. CONV lasts exactly 2*FRAME_BITS*SCLK_HALF clks.
- CONV → QUIET: on the clk after the FRAME_BITS-th rise strobe.
  - cs_n goes 1 and sclk stays 1.
  - The low DATA_BITS of the shift register load into sample.
  - The leading FRAME_BITS-DATA_BITS bits are discarded and not checked.
- QUIET: holds for QUIET_CLKS clks, then goes to CONV if en=1, otherwise IDLE.
- en deasserted mid-frame: the current frame completes, including its result and QUIET; the FSM then goes to IDLE.
- Handshake:
  - sample_valid sets on load.
  - sample_valid clears on the clk after sample_valid && sample_ready, unless a load happens on that same clk.
  - Load while sample_valid=1 and sample_ready=0: sample is overwritten, sample_valid stays 1, overrun=1 for that one clk.
  - Load while sample_valid=1 and sample_ready=1: the old sample is consumed, the new one loads, sample_valid stays 1, no overrun.
  - sample is stable whenever sample_valid=1 and no load occurs.
- rst mid-frame: cs_n=1 and sclk=1 on the next edge. No partial result is delivered.

Optional Feature:
ADC_AVG_EN — when defined:
- Each result is added into a DATA_BITS+2 accumulator, and a 2-bit frame counter advances.
- Every 4th frame, sample = accumulator>>2 (truncating) and the accumulator clears.
- sample_valid and overrun apply only to averaged outputs.
- rst clears the accumulator and the frame counter.
When undefined: every frame delivers its raw result; no accumulator logic is present.

Decomposition:
- Package adc_pkg holds:
  - state enum (IDLE, CONV, QUIET)
  - FRAME_BITS=16, DATA_BITS=12
  - AVG_FRAMES=4, AVG_SHIFT=2
- One sub-module, sclk_tick_gen:
  - half-period counter plus sclk register
  - inputs: run, SCLK_HALF
  - outputs: sclk, rise, fall strobes

Test Plan:
- Reset: hold rst 3 clks mid-CONV → on the next edge cs_n=1, sclk=1, sample_valid=0, sample=0, overrun=0; no valid appears afterwards.
- Single frame: SCLK_HALF=2, QUIET_CLKS=3, en pulsed 1 clk, ready=1, sdata drives 0000_1010_0101_1010 → cs_n low exactly 64 clks, 16 sclk periods, sample=0xA5A, valid for 1 clk, FSM ends in IDLE.
- Backpressure: ready=0, en=1, two frames with data 0x3C1 then 0x123 → after the 2nd frame sample=0x123, valid held, overrun=1 for exactly 1 clk; ready=1 then clears valid.
- Load coincident with ready: ready=1 on the exact load clk of the 2nd frame → valid stays 1, overrun=0, sample=new value.
- en drop: en deasserted during bit 7 → frame completes and delivers its sample, QUIET lasts QUIET_CLKS, cs_n stays 1 and the FSM stays in IDLE.
- ADC_AVG_EN: frames 0x100, 0x102, 0x104, 0x107 → single valid with sample=0x103 after the 4th frame, no valid after frames 1–3.
